// File: rtl/keypad_emulator.sv
// keypad_emulator: responder for the 4x4 Pmod keypad. It pulls the commanded key's
// active-low row low while that key's column strobe is low and the key is held.
// A valid/ready port sequences one press, hold and release per key code.
// Optional contact bounce is compiled in when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int unsigned PRESS_CYCLES  = 1000000,
    parameter int unsigned GAP_CYCLES    = 250000,
    parameter int unsigned BOUNCE_CYCLES = 8192,
    parameter int unsigned BOUNCE_TOGGLE = 512
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       pressed,
    output logic       key_done
);
    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_t;

    localparam logic [23:0] PRESS_LOAD = 24'(PRESS_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD   = 24'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_cnt;
    logic [3:0]  r_code;
    logic [3:0]  r_col_s1;
    logic [3:0]  r_col_s2;
    logic [3:0]  r_row;
    logic [1:0]  w_col_idx;
    logic [1:0]  w_row_idx;
    logic        w_pressed;
    logic        w_cnt_zero;

    // Reject parameter sets whose bounce window would outlast a phase.
    if (PRESS_CYCLES == 0 || PRESS_CYCLES > 32'hFF_FFFF || GAP_CYCLES == 0 || GAP_CYCLES > 32'hFF_FFFF ||
        BOUNCE_CYCLES >= PRESS_CYCLES || BOUNCE_CYCLES >= GAP_CYCLES || BOUNCE_TOGGLE == 0) begin : g_param_check
        $error("keypad_emulator: parameter out of range");
    end

    assign w_cnt_zero = (r_cnt == 24'd0);

    // State register with the phase counter and the latched key code.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (key_valid) begin
                    r_cnt  <= PRESS_LOAD;
                    r_code <= key_code;
                end
            end else if (w_cnt_zero) begin
                if (r_state == S_PRESS) r_cnt <= GAP_LOAD;
            end else begin
                r_cnt <= r_cnt - 24'd1;
            end
        end
    end

    // Next state: accept in IDLE, advance each phase when its counter expires.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = key_valid ? S_PRESS : S_IDLE;
            S_PRESS:   w_next = w_cnt_zero ? S_RELEASE : S_PRESS;
            S_RELEASE: w_next = w_cnt_zero ? S_IDLE : S_RELEASE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        key_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        key_done  = (r_state == S_RELEASE) && w_cnt_zero;
        pressed   = w_pressed;
        row       = r_row;
    end

    // Key code to {column strobe index, row return index}.
    always_comb begin
        {w_col_idx, w_row_idx} = 4'b0000;
        case (r_code)
            4'h0: {w_col_idx, w_row_idx} = {2'd3, 2'd0};
            4'h1: {w_col_idx, w_row_idx} = {2'd3, 2'd3};
            4'h2: {w_col_idx, w_row_idx} = {2'd2, 2'd3};
            4'h3: {w_col_idx, w_row_idx} = {2'd1, 2'd3};
            4'h4: {w_col_idx, w_row_idx} = {2'd3, 2'd2};
            4'h5: {w_col_idx, w_row_idx} = {2'd2, 2'd2};
            4'h6: {w_col_idx, w_row_idx} = {2'd1, 2'd2};
            4'h7: {w_col_idx, w_row_idx} = {2'd3, 2'd1};
            4'h8: {w_col_idx, w_row_idx} = {2'd2, 2'd1};
            4'h9: {w_col_idx, w_row_idx} = {2'd1, 2'd1};
            4'hA: {w_col_idx, w_row_idx} = {2'd0, 2'd3};
            4'hB: {w_col_idx, w_row_idx} = {2'd0, 2'd2};
            4'hC: {w_col_idx, w_row_idx} = {2'd0, 2'd1};
            4'hD: {w_col_idx, w_row_idx} = {2'd0, 2'd0};
            4'hE: {w_col_idx, w_row_idx} = {2'd1, 2'd0};
            default: {w_col_idx, w_row_idx} = {2'd2, 2'd0};
        endcase
    end

    // Two-flop column synchronizer feeding the registered row returns.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
            r_row    <= 4'hF;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
            r_row    <= (w_pressed && !r_col_s2[w_col_idx]) ? ~(4'b0001 << w_row_idx) : 4'hF;
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [23:0] BOUNCE_WIN = 24'(BOUNCE_CYCLES);
    localparam logic [23:0] TOGGLE_LAST = 24'(BOUNCE_TOGGLE - 1);

    logic [23:0] r_elapsed;
    logic [23:0] r_tick;
    logic        r_phase;

    // Elapsed-cycle and toggle counters restart on every state change; the contact
    // starts closed in PRESS and open in RELEASE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_elapsed <= '0;
            r_tick    <= '0;
            r_phase   <= 1'b0;
        end else if (w_next != r_state) begin
            r_elapsed <= '0;
            r_tick    <= '0;
            r_phase   <= (w_next == S_PRESS);
        end else begin
            if (r_elapsed != 24'hFF_FFFF) r_elapsed <= r_elapsed + 24'd1;
            r_tick  <= (r_tick == TOGGLE_LAST) ? 24'd0 : r_tick + 24'd1;
            r_phase <= r_phase ^ (r_tick == TOGGLE_LAST);
        end
    end

    assign w_pressed = (r_state != S_IDLE && r_elapsed < BOUNCE_WIN) ? r_phase : (r_state == S_PRESS);
`else
    assign w_pressed = (r_state == S_PRESS);
`endif

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table-driven key map vectors, timing sequences and a
// randomized run against a cycle-count reference model of keypad_emulator.
module tb_keypad_emulator;
    localparam int P = 100;
    localparam int G = 20;
    localparam int B = 8;
    localparam int T = 2;

    localparam logic [1:0] COLI [16] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3,
                                         2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    localparam logic [1:0] ROWI [16] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1,
                                         2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [3:0] SCAN [4] = '{4'h7, 4'hB, 4'hD, 4'hE};

    typedef struct {
        logic [3:0] code;
        logic [3:0] colv;
        logic [3:0] exp_row;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] col = 4'hF;
    logic [3:0] row;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic       busy;
    logic       pressed;
    logic       key_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int errs;
    int k;
    vec_t vt [20];

    logic [3:0] colh [$];
    logic [3:0] c3;
    logic [3:0] m_code;
    logic [3:0] m_row;
    logic [3:0] p_kc;
    logic [3:0] p_code;
    logic [1:0] si;
    logic       m_acc, m_busy, m_press, m_done, p_ready, p_kv, p_press;
    int         m_edge;

    keypad_emulator #(
        .PRESS_CYCLES(P), .GAP_CYCLES(G), .BOUNCE_CYCLES(B), .BOUNCE_TOGGLE(T)
    ) dut (
        .clk(clk), .clr(clr), .col(col), .row(row), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .busy(busy), .pressed(pressed), .key_done(key_done)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (key_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk_b(name, key_done, 1'b1);
    endtask

    task automatic idle_outputs(input string name);
        chk_v({name, "_row"}, row, 4'hF);
        chk_b({name, "_ready"}, key_ready, 1'b1);
        chk_b({name, "_busy"}, busy, 1'b0);
        chk_b({name, "_pressed"}, pressed, 1'b0);
        chk_b({name, "_done"}, key_done, 1'b0);
    endtask

    // Expected contact state k cycles after acceptance, from the phase lengths and bounce rules.
    function automatic logic model_press(input int kk);
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (kk < B) return ((kk / T) % 2) == 0;
        if (kk < P) return 1'b1;
        if (kk < P + B) return ((kk - P) / T) % 2 == 1;
        return 1'b0;
`else
        return kk < P;
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{4'h0, 4'h7, 4'hE};
        vt[1]  = '{4'h1, 4'h7, 4'h7};
        vt[2]  = '{4'h2, 4'hB, 4'h7};
        vt[3]  = '{4'h3, 4'hD, 4'h7};
        vt[4]  = '{4'h4, 4'h7, 4'hB};
        vt[5]  = '{4'h5, 4'hB, 4'hB};
        vt[6]  = '{4'h6, 4'hD, 4'hB};
        vt[7]  = '{4'h7, 4'h7, 4'hD};
        vt[8]  = '{4'h8, 4'hB, 4'hD};
        vt[9]  = '{4'h9, 4'hD, 4'hD};
        vt[10] = '{4'hA, 4'hE, 4'h7};
        vt[11] = '{4'hB, 4'hE, 4'hB};
        vt[12] = '{4'hC, 4'hE, 4'hD};
        vt[13] = '{4'hD, 4'hE, 4'hE};
        vt[14] = '{4'hE, 4'hD, 4'hE};
        vt[15] = '{4'hF, 4'hB, 4'hE};
        vt[16] = '{4'h5, 4'hE, 4'hF};
        vt[17] = '{4'hD, 4'h0, 4'hE};
        vt[18] = '{4'hA, 4'h1, 4'hF};
        vt[19] = '{4'h1, 4'h8, 4'hF};

        clr = 1'b0;
        #1 clr = 1'b1;
        #2 idle_outputs("reset_hold");
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        idle_outputs("reset_release");

        // Key map vectors: one full command per entry with col held still.
        for (int i = 0; i < 20; i++) begin
            col = vt[i].colv;
            repeat (3) tick();
            chk_b("vec_ready", key_ready, 1'b1);
            key_code  = vt[i].code;
            key_valid = 1'b1;
            tick();
            key_valid = 1'b0;
            chk_b("vec_busy", busy, 1'b1);
            chk_b("vec_pressed", pressed, 1'b1);
            tick();
            chk_v($sformatf("vec%0d_row", i), row, vt[i].exp_row);
            wait_done("vec_done", cyc);
            chk_i("vec_len", cyc, P + G - 2);
            tick();
        end

        // Key D on a steady column: exact row window and key_done position.
        col = 4'hE;
        repeat (3) tick();
        key_code  = 4'hD;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk_b("d_accept_busy", busy, 1'b1);
        chk_b("d_accept_ready", key_ready, 1'b0);
        errs = 0;
        for (int i = 1; i <= P; i++) begin
            tick();
            if (row !== 4'hE) errs++;
        end
        chk_i("d_row_low_span", errs, 0);
        tick();
        chk_v("d_row_release", row, 4'hF);
        chk_b("d_pressed_release", pressed, 1'b0);
        chk_b("d_busy_release", busy, 1'b1);
        repeat (G - 3) tick();
        chk_b("d_done_early", key_done, 1'b0);
        tick();
        chk_b("d_done", key_done, 1'b1);
        tick();
        chk_b("d_done_once", key_done, 1'b0);
        chk_b("d_ready_after", key_ready, 1'b1);

        // Back-to-back commands with key_valid held and key_code churning while busy.
        col = 4'h6;
        repeat (3) tick();
        key_code  = 4'h1;
        key_valid = 1'b1;
        tick();
        chk_b("b2b_first_busy", busy, 1'b1);
        errs = 0;
        for (int i = 1; i <= P; i++) begin
            key_code = 4'($urandom);
            tick();
            if (row !== 4'h7) errs++;
        end
        chk_i("b2b_code_ignored", errs, 0);
        key_code = 4'hA;
        wait_done("b2b_first_done", cyc);
        tick();
        chk_b("b2b_gap_ready", key_ready, 1'b1);
        chk_b("b2b_gap_busy", busy, 1'b0);
        tick();
        key_valid = 1'b0;
        chk_b("b2b_second_busy", busy, 1'b1);
        chk_b("b2b_second_pressed", pressed, 1'b1);
        tick();
        chk_v("b2b_second_row", row, 4'h7);
        wait_done("b2b_second_done", cyc);
        chk_i("b2b_second_len", cyc, P + G - 2);
        tick();

        // Reset mid-press, then a clean full sequence.
        col = 4'hE;
        repeat (3) tick();
        key_code  = 4'hD;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (50) tick();
        chk_v("rst_row_before", row, 4'hE);
        #3 clr = 1'b1;
        #1 idle_outputs("rst_async");
        errs = 0;
        repeat (3) begin
            tick();
            if (key_done !== 1'b0 || row !== 4'hF || busy !== 1'b0) errs++;
        end
        clr = 1'b0;
        repeat (3) begin
            tick();
            if (key_done !== 1'b0 || row !== 4'hF || busy !== 1'b0) errs++;
        end
        chk_i("rst_quiet", errs, 0);
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        chk_b("rst_next_busy", busy, 1'b1);
        wait_done("rst_next_done", cyc);
        chk_i("rst_next_len", cyc, P + G - 1);
        tick();
        chk_b("rst_next_ready", key_ready, 1'b1);

`ifdef KEYPAD_EMU_BOUNCE_EN
        // Bounce windows at the start of PRESS and RELEASE for key 0 on col[3].
        col = 4'h7;
        repeat (3) tick();
        key_code  = 4'h0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        begin
            int pe, re, de;
            logic pp;
            pe = 0; re = 0; de = 0; pp = 1'b0;
            for (int kk = 0; kk < P + G; kk++) begin
                if (pressed !== model_press(kk)) pe++;
                if (kk > 0 && row[0] !== ~pp) re++;
                if (key_done !== (kk == P + G - 1)) de++;
                pp = model_press(kk);
                if (kk < P + G - 1) tick();
            end
            chk_i("bounce_pressed", pe, 0);
            chk_i("bounce_row0", re, 0);
            chk_i("bounce_done", de, 0);
        end
        tick();
        chk_v("bounce_row_idle", row, 4'hF);
`endif

        // Randomized run against the reference model; first command is key 5 under the scanner.
        col = 4'hF;
        key_valid = 1'b0;
        repeat (4) tick();
        colh = '{4'hF, 4'hF, 4'hF};
        m_acc = 1'b0; m_edge = 0; m_code = 4'h0;
        p_ready = 1'b1; p_press = 1'b0; p_code = 4'h0;
        key_valid = 1'b1; key_code = 4'h5;
        p_kv = 1'b1; p_kc = 4'h5;
        for (int j = 1; j <= 4000; j++) begin
            tick();
            if (p_ready && p_kv) begin
                m_acc  = 1'b1;
                m_edge = j;
                m_code = p_kc;
            end
            k = j - m_edge;
            m_busy  = m_acc && k < P + G;
            m_press = m_acc && model_press(k);
            m_done  = m_acc && k == P + G - 1;
            c3 = colh[0];
            m_row = 4'hF;
            if (p_press && c3[COLI[p_code]] == 1'b0) m_row[ROWI[p_code]] = 1'b0;
            chk_v("rnd_row", row, m_row);
            chk_b("rnd_busy", busy, m_busy);
            chk_b("rnd_ready", key_ready, !m_busy);
            chk_b("rnd_pressed", pressed, m_press);
            chk_b("rnd_done", key_done, m_done);
            if (j < 1500) begin
                si  = 2'(j / 8);
                col = SCAN[si];
            end else if ($urandom_range(0, 3) == 0) begin
                col = 4'($urandom);
            end
            if (j > 1) begin
                key_valid = ($urandom_range(0, 2) == 0);
                key_code  = 4'($urandom);
            end
            p_kv    = key_valid;
            p_kc    = key_code;
            p_ready = !m_busy;
            p_press = m_press;
            p_code  = m_code;
            colh.push_back(col);
            void'(colh.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
